// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Contents: default widths, the register count, the requester
// enumeration, the holding-slot record layout and the age
// comparison used to pick the older of two held writes.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREG   = 2 ** RF_ADDR_W;
    localparam int AGE_W     = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_M = 1'b1
    } req_e;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
        logic [AGE_W-1:0]     age;
    } slot_t;

    // Age counts cycles since the slot was loaded, so a larger age means an
    // earlier load. Equal ages mean both loaded on the same edge; the caller
    // breaks that tie.
    function automatic logic a_is_older(input logic [AGE_W-1:0] a_age,
                                        input logic [AGE_W-1:0] m_age);
        return a_age > m_age;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One writeback holding entry with an age stamp.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   load_i          capture rd_i/data_i this edge (takes priority over drain)
//   drain_i         entry was granted this cycle; empties on the edge
//   rd_i, data_i    incoming destination register and data
//   valid_o, rd_o, data_o, age_o   current entry contents
// The age is zero on the cycle after a load and counts up (saturating)
// while the entry waits, so the arbiter can tell which entry is older.
module wb_slot
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0] data_o,
    output logic [AGE_W-1:0]  age_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AGE_W-1:0]  age_q, age_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        age_d   = age_q;
        if (load_i) begin
            valid_d = 1'b1;
            rd_d    = rd_i;
            data_d  = data_i;
            age_d   = '0;
        end else if (drain_i) begin
            valid_d = 1'b0;
            age_d   = '0;
        end else if (valid_q && (age_q != '1)) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    // Only control state is reset; rd/data are don't-care while invalid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;
    assign age_o   = age_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single rf write port between the ALU (A) and load (M)
// writeback paths. Each path owns a one-entry holding slot; at most one
// slot drains per cycle, oldest first, with M winning a same-edge tie.
// Ports:
//   Clk, Rst                     clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data  ALU writeback request handshake
//   m_valid/m_ready/m_rd/m_data  load writeback request handshake
//   WrEn, Rw, busW               rf write port (R0 never written)
//   pend_mask                    one bit per register with a held write
//   byp_ra/byp_hit/byp_data      bypass lookup into the held slots
// Optional feature macro: RF_WB_BYPASS_EN enables the byp_* ports and the
// lookup; without it those ports do not exist.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_rd,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [ADDR_W-1:0]    m_rd,
    input  logic [DATA_W-1:0]    m_data,
    output logic                 WrEn,
    output logic [ADDR_W-1:0]    Rw,
    output logic [DATA_W-1:0]    busW,
    output logic [2**ADDR_W-1:0] pend_mask
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]    byp_ra,
    output logic                 byp_hit,
    output logic [DATA_W-1:0]    byp_data
`endif
);

    logic              a_vld, m_vld;
    logic [ADDR_W-1:0] a_rd_s, m_rd_s;
    logic [DATA_W-1:0] a_data_s, m_data_s;
    logic [AGE_W-1:0]  a_age, m_age;

    logic grant_any, grant_a, grant_m;
    req_e win;

    // Grant looks only at slot state (never at *_valid), so ready has no
    // combinational path back to the requesters. Reset suppresses any grant
    // so nothing is written or accepted in a reset cycle.
    always_comb begin
        grant_any = 1'b0;
        win       = REQ_M;
        if (!Rst) begin
            if (a_vld && m_vld) begin
                grant_any = 1'b1;
                win       = a_is_older(a_age, m_age) ? REQ_A : REQ_M;
            end else if (a_vld) begin
                grant_any = 1'b1;
                win       = REQ_A;
            end else if (m_vld) begin
                grant_any = 1'b1;
                win       = REQ_M;
            end
        end
    end

    assign grant_a = grant_any && (win == REQ_A);
    assign grant_m = grant_any && (win == REQ_M);

    // A slot can accept when empty or when it drains this same edge.
    assign a_ready = !Rst && (!a_vld || grant_a);
    assign m_ready = !Rst && (!m_vld || grant_m);

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .Clk     (Clk),
        .Rst     (Rst),
        .load_i  (a_valid && a_ready),
        .drain_i (grant_a),
        .rd_i    (a_rd),
        .data_i  (a_data),
        .valid_o (a_vld),
        .rd_o    (a_rd_s),
        .data_o  (a_data_s),
        .age_o   (a_age)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_m (
        .Clk     (Clk),
        .Rst     (Rst),
        .load_i  (m_valid && m_ready),
        .drain_i (grant_m),
        .rd_i    (m_rd),
        .data_i  (m_data),
        .valid_o (m_vld),
        .rd_o    (m_rd_s),
        .data_o  (m_data_s),
        .age_o   (m_age)
    );

    // A write to R0 still drains its slot but never raises WrEn.
    always_comb begin
        Rw   = '0;
        busW = '0;
        if (grant_a) begin
            Rw   = a_rd_s;
            busW = a_data_s;
        end else if (grant_m) begin
            Rw   = m_rd_s;
            busW = m_data_s;
        end
        WrEn = grant_any && (Rw != '0);
    end

    always_comb begin
        pend_mask = '0;
        if (a_vld && (a_rd_s != '0)) pend_mask[a_rd_s] = 1'b1;
        if (m_vld && (m_rd_s != '0)) pend_mask[m_rd_s] = 1'b1;
    end

`ifdef RF_WB_BYPASS_EN
    logic hit_a, hit_m;

    assign hit_a = a_vld && (a_rd_s == byp_ra) && (byp_ra != '0);
    assign hit_m = m_vld && (m_rd_s == byp_ra) && (byp_ra != '0);

    // On a double hit the younger slot holds the value the rf will end up
    // with; a same-edge tie goes to A because M is written first.
    always_comb begin
        byp_hit  = hit_a || hit_m;
        byp_data = '0;
        if (hit_a && (!hit_m || !a_is_older(a_age, m_age))) begin
            byp_data = a_data_s;
        end else if (hit_m) begin
            byp_data = m_data_s;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter.
// A reference model tracks each held write with the cycle number it was
// accepted in; the oldest (smallest number) drains first, ties go to M.
// Every cycle the DUT handshake, write port and pending mask are compared
// with the model; directed scenarios add literal expectations.
module tb_rf_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            a_valid, m_valid;
    logic            a_ready, m_ready;
    logic [AW-1:0]   a_rd, m_rd;
    logic [DW-1:0]   a_data, m_data;
    logic            WrEn;
    logic [AW-1:0]   Rw;
    logic [DW-1:0]   busW;
    logic [NREG-1:0] pend_mask;
    logic [AW-1:0]   byp_ra;
`ifdef RF_WB_BYPASS_EN
    logic            byp_hit;
    logic [DW-1:0]   byp_data;
`endif

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_rd      (m_rd),
        .m_data    (m_data),
        .WrEn      (WrEn),
        .Rw        (Rw),
        .busW      (busW),
        .pend_mask (pend_mask)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp_ra    (byp_ra),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit            v;
        int            rd;
        logic [DW-1:0] data;
        int            t;
    } mslot_t;

    mslot_t ma, mm;
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     chk_en = 0;
    int     dut_wr = 0;
    int     mdl_wr = 0;
    logic [DW-1:0] rf_dut [NREG];

    // Samples of the DUT outputs for the cycle just completed.
    logic            s_ar, s_mr, s_wren;
    logic [AW-1:0]   s_rw;
    logic [DW-1:0]   s_busw;
    logic [NREG-1:0] s_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drv(input bit av, input int ard, input logic [DW-1:0] ad,
                       input bit mv, input int mrd, input logic [DW-1:0] md);
        a_valid = av;
        a_rd    = AW'(ard);
        a_data  = ad;
        m_valid = mv;
        m_rd    = AW'(mrd);
        m_data  = md;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the
    // rising edge, return just after it so the caller can change inputs.
    task automatic cycle();
        bit              ga, gm, ear, emr, ewr;
        int              erw;
        logic [DW-1:0]   ebus;
        logic [NREG-1:0] ep;
        @(negedge Clk);
        s_ar   = a_ready;
        s_mr   = m_ready;
        s_wren = WrEn;
        s_rw   = Rw;
        s_busw = busW;
        s_pend = pend_mask;

        ga  = !Rst && ma.v && (!mm.v || ma.t < mm.t);
        gm  = !Rst && mm.v && (!ma.v || mm.t <= ma.t);
        ear = !Rst && (!ma.v || ga);
        emr = !Rst && (!mm.v || gm);
        erw  = ga ? ma.rd : (gm ? mm.rd : 0);
        ebus = ga ? ma.data : (gm ? mm.data : '0);
        ewr  = (ga || gm) && (erw != 0);
        ep = '0;
        if (ma.v && ma.rd != 0) ep[ma.rd] = 1'b1;
        if (mm.v && mm.rd != 0) ep[mm.rd] = 1'b1;

        if (chk_en) begin
            chk("a_ready", 64'(s_ar), 64'(ear));
            chk("m_ready", 64'(s_mr), 64'(emr));
            chk("WrEn", 64'(s_wren), 64'(ewr));
            chk("pend_mask", 64'(s_pend), 64'(ep));
            if (ewr) begin
                chk("Rw", 64'(s_rw), 64'(erw));
                chk("busW", 64'(s_busw), 64'(ebus));
            end else if (!ga && !gm) begin
                chk("Rw_idle", 64'(s_rw), 64'd0);
                chk("busW_idle", 64'(s_busw), 64'd0);
            end
`ifdef RF_WB_BYPASS_EN
            begin
                bit            ha, hm, eh;
                logic [DW-1:0] ed;
                ha = ma.v && (ma.rd == int'(byp_ra)) && (byp_ra != 0);
                hm = mm.v && (mm.rd == int'(byp_ra)) && (byp_ra != 0);
                eh = ha || hm;
                ed = '0;
                if (ha && hm) ed = (ma.t >= mm.t) ? ma.data : mm.data;
                else if (ha)  ed = ma.data;
                else if (hm)  ed = mm.data;
                chk("byp_hit", 64'(byp_hit), 64'(eh));
                chk("byp_data", 64'(byp_data), 64'(ed));
            end
`endif
        end
        if (s_wren) begin
            rf_dut[s_rw] = s_busw;
            dut_wr++;
        end

        @(posedge Clk);
        if (ewr) mdl_wr++;
        if (Rst) begin
            ma.v = 0;
            mm.v = 0;
        end else begin
            if (a_valid && ear) ma = '{1, int'(a_rd), a_data, cyc};
            else if (ga)        ma.v = 0;
            if (m_valid && emr) mm = '{1, int'(m_rd), m_data, cyc};
            else if (gm)        mm.v = 0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int common;
        ma = '{0, 0, '0, 0};
        mm = '{0, 0, '0, 0};
        for (int i = 0; i < NREG; i++) rf_dut[i] = '0;
        byp_ra = '0;

        // Reset with a request pending: nothing may be accepted or written.
        Rst = 1'b1;
        drv(1, 3, 32'hDEAD, 0, 0, 0);
        cycle();
        chk_en = 1;
        cycle();
        chk("t1_wren_rst", 64'(s_wren), 64'd0);
        chk("t1_pend_rst", 64'(s_pend), 64'd0);
        chk("t1_aready_rst", 64'(s_ar), 64'd0);
        Rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_aready_rel", 64'(s_ar), 64'd1);
        chk("t1_wren_rel", 64'(s_wren), 64'd0);

        // Single ALU write.
        drv(1, 8, 32'd1, 0, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        chk("t2_wren", 64'(s_wren), 64'd1);
        chk("t2_rw", 64'(s_rw), 64'd8);
        chk("t2_busw", 64'(s_busw), 64'd1);
        chk("t2_pend8", 64'(s_pend[8]), 64'd1);
        cycle();
        chk("t2_pend_after", 64'(s_pend), 64'd0);
        chk("t2_wren_after", 64'(s_wren), 64'd0);

        // Same-edge acceptance: M drains first, then A.
        drv(1, 9, 32'd2, 1, 12, 32'h20);
        cycle();
        chk("t3_ar0", 64'(s_ar), 64'd1);
        chk("t3_mr0", 64'(s_mr), 64'd1);
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        chk("t3_rw1", 64'(s_rw), 64'd12);
        chk("t3_bus1", 64'(s_busw), 64'h20);
        chk("t3_mr1", 64'(s_mr), 64'd1);
        chk("t3_ar1", 64'(s_ar), 64'd0);
        chk("t3_pend1", 64'(s_pend), 64'(1 << 9) | 64'(1 << 12));
        cycle();
        chk("t3_rw2", 64'(s_rw), 64'd9);
        chk("t3_bus2", 64'(s_busw), 64'd2);
        chk("t3_ar2", 64'(s_ar), 64'd1);

        // Same destination from both paths: the later value must stick.
        drv(1, 15, 32'h3001, 0, 0, 0);
        cycle();
        drv(0, 0, 0, 1, 15, 32'h6002);
        cycle();
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("t4_r15", 64'(rf_dut[15]), 64'h6002);

        // Load to R0: accepted, never written, never pending.
        drv(0, 0, 0, 1, 0, 32'hFFFF);
        cycle();
        chk("t5_mr", 64'(s_mr), 64'd1);
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        chk("t5_wren", 64'(s_wren), 64'd0);
        chk("t5_pend", 64'(s_pend), 64'd0);

        // Reset while both slots hold writes: discarded, no write.
        drv(1, 4, 32'h44, 1, 5, 32'h55);
        cycle();
        drv(0, 0, 0, 0, 0, 0);
        Rst = 1'b1;
        cycle();
        chk("t7_wren_rst", 64'(s_wren), 64'd0);
        Rst = 1'b0;
        cycle();
        chk("t7_pend_after", 64'(s_pend), 64'd0);
        chk("t7_wren_after", 64'(s_wren), 64'd0);

        // Continuous streams from both requesters.
        for (int i = 0; i < 20; i++) begin
            drv(1, $urandom_range(1, NREG - 1), $urandom, 1, $urandom_range(1, NREG - 1), $urandom);
            byp_ra = (i % 2) ? AW'(ma.rd) : AW'(mm.rd);
            cycle();
            if (i >= 1) chk("t6_one_write", 64'(s_wren), 64'd1);
        end

        // Random traffic with colliding destinations, R0 and rare resets.
        for (int i = 0; i < 300; i++) begin
            common = $urandom_range(0, 3);
            drv($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? common : $urandom_range(0, NREG - 1), $urandom,
                $urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? common : $urandom_range(0, NREG - 1), $urandom);
            case ($urandom_range(0, 2))
                0:       byp_ra = AW'(ma.rd);
                1:       byp_ra = AW'(mm.rd);
                default: byp_ra = AW'($urandom_range(0, NREG - 1));
            endcase
            Rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        Rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("drained_pend", 64'(s_pend), 64'd0);
        chk("write_count", 64'(dut_wr), 64'(mdl_wr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
